// File: rtl/pid_pkg.sv
// Shared types and helpers for the multi-channel velocity-form PID controller.
package pid_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_K1   = 2'd0,
    SEL_K2   = 2'd1,
    SEL_K3   = 2'd2,
    SEL_NONE = 2'd3
  } cfg_sel_t;

  localparam int SAT_W = 64;

  // Clamp x to the signed range of a w-bit word; clipped reports whether it moved.
  function automatic logic signed [SAT_W-1:0] saturate(
    input  logic signed [SAT_W-1:0] x,
    input  int                      w,
    output logic                    clipped
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    clipped = 1'b1;
    if (x > hi)      saturate = hi;
    else if (x < lo) saturate = lo;
    else begin
      saturate = x;
      clipped  = 1'b0;
    end
  endfunction

endpackage

// File: rtl/pid_mc_regfile.sv
// Per-channel PID history (u_prev, e1, e2) and gains, with one read port,
// one write-back port, a gain config port and a history clear port.
module pid_mc_regfile
  import pid_pkg::*;
#(
  parameter int W      = 8,
  parameter int CH     = 4,
  parameter int GW     = 8,
  parameter int CW     = 2,
  parameter int K1_RST = 107,
  parameter int K2_RST = 104,
  parameter int K3_RST = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CW-1:0]        rd_ch,
  output logic signed [W-1:0]  rd_u_prev,
  output logic signed [W-1:0]  rd_e1,
  output logic signed [W-1:0]  rd_e2,
  output logic signed [GW-1:0] rd_k1,
  output logic signed [GW-1:0] rd_k2,
  output logic signed [GW-1:0] rd_k3,
  input  logic                 wb_en,
  input  logic [CW-1:0]        wb_ch,
  input  logic signed [W-1:0]  wb_u,
  input  logic signed [W-1:0]  wb_e1,
  input  logic signed [W-1:0]  wb_e2,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_ch,
  input  logic [1:0]           cfg_sel,
  input  logic signed [GW-1:0] cfg_data,
  input  logic                 clr_valid,
  input  logic [CW-1:0]        clr_ch
);

  logic signed [W-1:0]  r_u_prev [CH];
  logic signed [W-1:0]  r_e1     [CH];
  logic signed [W-1:0]  r_e2     [CH];
  logic signed [GW-1:0] r_k1     [CH];
  logic signed [GW-1:0] r_k2     [CH];
  logic signed [GW-1:0] r_k3     [CH];
  logic [CW-1:0]        w_rd_idx;

  // Guard against non-power-of-two CH; the FSM only ever reads valid channels.
  assign w_rd_idx  = ({1'b0, rd_ch} < (CW + 1)'(CH)) ? rd_ch : '0;
  assign rd_u_prev = r_u_prev[w_rd_idx];
  assign rd_e1     = r_e1[w_rd_idx];
  assign rd_e2     = r_e2[w_rd_idx];
  assign rd_k1     = r_k1[w_rd_idx];
  assign rd_k2     = r_k2[w_rd_idx];
  assign rd_k3     = r_k3[w_rd_idx];

  // NOTE: this is a small flop array, not a RAM, so every entry gets a reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        r_u_prev[i] <= '0;
        r_e1[i]     <= '0;
        r_e2[i]     <= '0;
        r_k1[i]     <= GW'(K1_RST);
        r_k2[i]     <= GW'(K2_RST);
        r_k3[i]     <= GW'(K3_RST);
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        // NOTE: a clear wins over a same-cycle write-back to the same channel.
        if (clr_valid && clr_ch == CW'(i)) begin
          r_u_prev[i] <= '0;
          r_e1[i]     <= '0;
          r_e2[i]     <= '0;
        end else if (wb_en && wb_ch == CW'(i)) begin
          r_u_prev[i] <= wb_u;
          r_e1[i]     <= wb_e1;
          r_e2[i]     <= wb_e2;
        end
        if (cfg_we && cfg_ch == CW'(i)) begin
          case (cfg_sel_t'(cfg_sel))
            SEL_K1:  r_k1[i] <= cfg_data;
            SEL_K2:  r_k2[i] <= cfg_data;
            SEL_K3:  r_k3[i] <= cfg_data;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/pid_mc.sv
// Time-multiplexed incremental PID: one error sample in, one saturated
// control word out four cycles later, state kept per channel.
module pid_mc
  import pid_pkg::*;
#(
  parameter  int W      = 8,
  parameter  int CH     = 4,
  parameter  int GW     = 8,
  parameter  int FRAC   = 0,
  parameter  int K1_RST = 107,
  parameter  int K2_RST = 104,
  parameter  int K3_RST = 2,
  localparam int CW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [W-1:0]  in_e,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic signed [W-1:0]  out_u,
  output logic                 out_sat,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_ch,
  input  logic [1:0]           cfg_sel,
  input  logic signed [GW-1:0] cfg_data,
  input  logic                 clr_valid,
  input  logic [CW-1:0]        clr_ch
);

  localparam int PW = W + GW;
  localparam int AW = W + GW + 3;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_ch;
  logic signed [W-1:0]   r_e;
  logic signed [W-1:0]   r_u_prev;
  logic signed [W-1:0]   r_e1;
  logic signed [PW-1:0]  r_p1, r_p2, r_p3;
  logic                  r_kill;
  logic [CW-1:0]         r_out_ch;
  logic signed [W-1:0]   r_out_u;
  logic                  r_out_sat;

  logic signed [W-1:0]   w_u_prev, w_e1, w_e2;
  logic signed [GW-1:0]  w_k1, w_k2, w_k3;
  logic signed [PW-1:0]  w_p1, w_p2, w_p3;
  logic signed [AW-1:0]  w_acc, w_inc;
  logic signed [AW:0]    w_sum;
  logic signed [W-1:0]   w_u;
  logic                  w_clip;
  logic                  w_in_ch_ok;
  logic                  w_accept;
  logic                  w_wb_en;

  pid_mc_regfile #(
    .W(W), .CH(CH), .GW(GW), .CW(CW),
    .K1_RST(K1_RST), .K2_RST(K2_RST), .K3_RST(K3_RST)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_ch     (r_ch),
    .rd_u_prev (w_u_prev),
    .rd_e1     (w_e1),
    .rd_e2     (w_e2),
    .rd_k1     (w_k1),
    .rd_k2     (w_k2),
    .rd_k3     (w_k3),
    .wb_en     (w_wb_en),
    .wb_ch     (r_ch),
    .wb_u      (r_out_u),
    .wb_e1     (r_e),
    .wb_e2     (r_e1),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .clr_valid (clr_valid),
    .clr_ch    (clr_ch)
  );

  assign w_in_ch_ok = {1'b0, in_ch} < (CW + 1)'(CH);
  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_OUT);
  assign out_ch     = r_out_ch;
  assign out_u      = r_out_u;
  assign out_sat    = r_out_sat;
  assign w_wb_en    = (r_state == S_OUT) && !r_kill;

  // Out-of-range channels are consumed in IDLE without starting a pass.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_in_ch_ok) w_next = S_MUL;
      S_MUL:   w_next = S_ACC;
      S_ACC:   w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sized casts keep both operands signed and at full product width.
  always_comb begin
    w_p1  = PW'(w_k1) * PW'(r_e);
    w_p2  = PW'(w_k2) * PW'(w_e1);
    w_p3  = PW'(w_k3) * PW'(w_e2);
    w_acc = AW'(r_p1) - AW'(r_p2) + AW'(r_p3);
    w_inc = w_acc >>> FRAC;
    w_sum = (AW + 1)'(r_u_prev) + (AW + 1)'(w_inc);
    w_clip = 1'b0;
    w_u   = W'(saturate(SAT_W'(w_sum), W, w_clip));
  end

  // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_e       <= '0;
      r_u_prev  <= '0;
      r_e1      <= '0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_p3      <= '0;
      r_kill    <= 1'b0;
      r_out_ch  <= '0;
      r_out_u   <= '0;
      r_out_sat <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_in_ch_ok) begin
            r_ch   <= in_ch;
            r_e    <= in_e;
            r_kill <= 1'b0;
          end
        end
        S_MUL: begin
          r_p1     <= w_p1;
          r_p2     <= w_p2;
          r_p3     <= w_p3;
          r_u_prev <= w_u_prev;
          r_e1     <= w_e1;
          if (clr_valid && clr_ch == r_ch) r_kill <= 1'b1;
        end
        S_ACC: begin
          r_out_ch  <= r_ch;
          r_out_u   <= w_u;
          r_out_sat <= w_clip;
          if (clr_valid && clr_ch == r_ch) r_kill <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_mc.sv
// Directed self-checking bench for pid_mc with default parameters.
module tb_pid_mc;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_ch;
  logic signed [7:0] in_e;
  logic              out_valid;
  logic [1:0]        out_ch;
  logic signed [7:0] out_u;
  logic              out_sat;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [1:0]        cfg_sel;
  logic signed [7:0] cfg_data;
  logic              clr_valid;
  logic [1:0]        clr_ch;

  int n_total = 0;
  int n_bad   = 0;

  pid_mc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_e      (in_e),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_u     (out_u),
    .out_sat   (out_sat),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .clr_valid (clr_valid),
    .clr_ch    (clr_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_sel  = 2'(sel);
    cfg_data = 8'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Starts and ends on a negedge; optionally fires a preset gain write in
  // MUL or a clear of the same channel in ACC.
  task automatic send(input string tag, input int ch, input int e,
                      input int exp_u, input int exp_sat,
                      input bit cfg_in_mul, input bit clr_in_acc);
    check({tag, "/ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_e     = 8'(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "/busy"}, int'(in_ready), 0);
    if (cfg_in_mul) cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    check({tag, "/early"}, int'(out_valid), 0);
    if (clr_in_acc) begin
      clr_valid = 1'b1;
      clr_ch    = 2'(ch);
    end
    @(negedge clk);
    clr_valid = 1'b0;
    check({tag, "/valid"}, int'(out_valid), 1);
    check({tag, "/ch"},    int'(out_ch), ch);
    check({tag, "/u"},     int'(out_u), exp_u);
    check({tag, "/sat"},   int'(out_sat), exp_sat);
    @(negedge clk);
    check({tag, "/pulse"}, int'(out_valid), 0);
  endtask

  initial begin
    int pulses;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_e      = '0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_sel   = '0;
    cfg_data  = '0;
    clr_valid = 1'b0;
    clr_ch    = '0;
    repeat (3) @(negedge clk);
    check("rst/in_ready",  int'(in_ready), 1);
    check("rst/out_valid", int'(out_valid), 0);
    check("rst/out_ch",    int'(out_ch), 0);
    check("rst/out_u",     int'(out_u), 0);
    check("rst/out_sat",   int'(out_sat), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Default gains k1=107 k2=104 k3=2 on ch0, then saturation and recovery.
    send("c0_a", 0, 1, 107, 0, 0, 0);
    send("c0_b", 0, 1, 110, 0, 0, 0);
    send("c0_c", 0, 1, 115, 0, 0, 0);
    send("c0_sat", 0, 2, 127, 1, 0, 0);
    send("c0_unwind", 0, 0, -79, 0, 0, 0);

    // Interleaved channels keep independent history.
    send("mix_c0_a", 0, 1, 32, 0, 0, 0);
    send("mix_c1_a", 1, -1, -107, 0, 0, 0);
    send("mix_c0_b", 0, 1, 35, 0, 0, 0);
    send("mix_c1_b", 1, -1, -110, 0, 0, 0);
    send("mix_c1_neg", 1, -2, -128, 1, 0, 0);

    // Clear during ACC: result still emitted, history wiped afterwards.
    send("clr_inflight", 0, 1, 40, 0, 0, 1);
    send("clr_after", 0, 1, 107, 0, 0, 0);

    // Runtime gain write; cfg_sel=3 must be ignored.
    cfg_write(2, 0, 3);
    cfg_write(2, 3, 50);
    send("gain_c2", 2, 3, 9, 0, 0, 0);

    // Gain write during MUL applies only to the following sample.
    cfg_ch   = 2'd3;
    cfg_sel  = 2'd0;
    cfg_data = 8'sd5;
    send("gain_mul_old", 3, 1, 107, 0, 1, 0);
    send("gain_mul_new", 3, 0, 3, 0, 0, 0);

    // Reset in MUL aborts the sample.
    in_valid = 1'b1;
    in_ch    = 2'd0;
    in_e     = 8'sd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("rst_mid/no_pulse", pulses, 0);
    check("rst_mid/in_ready", int'(in_ready), 1);
    send("rst_mid/after", 0, 1, 107, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pid_mc.md
# pid_mc

Multi-channel, time-multiplexed incremental (velocity-form) PID controller with per-channel runtime gains, fractional gain scaling and saturating anti-windup output. It replaces the single-channel fixed-gain PID in the motor-control path. One instance serves up to CH motor loops, accepting one error sample per handshake and returning one control word per accepted sample.

## Interface
- W, 8, data width of error and control words (signed)
- CH, 4, number of channels (1..16)
- GW, 8, gain width (signed)
- FRAC, 0, fractional bits in gains; product sum is arithmetic-shifted right by FRAC
- K1_RST / K2_RST / K3_RST, 107 / 104 / 2, gain values loaded into every channel at reset

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  error sample offered
- in_ready  out  1  block can accept a sample this cycle
- in_ch  in  CW=max(1,$clog2(CH))  channel of sample
- in_e  in  W  signed error e[n]
- out_valid  out  1  one-cycle pulse, result valid
- out_ch  out  CW  channel of result
- out_u  out  W  signed control u[n]
- out_sat  out  1  result was clipped
- cfg_we  in  1  gain write strobe
- cfg_ch  in  CW  target channel
- cfg_sel  in  2  0=k1, 1=k2, 2=k3, 3=ignored
- cfg_data  in  GW  signed gain value
- clr_valid  in  1  clear channel history
- clr_ch  in  CW  channel to clear

## Operation
- Per-channel state: u_prev, e1, e2 (W bits each), k1, k2, k3 (GW bits each).
- Law: acc = k1*e[n] − k2*e1 + k3*e2, width W+GW+3 signed; inc = acc >>> FRAC; sum = u_prev + inc; u = saturate(sum) to [−2^(W−1), 2^(W−1)−1]; out_sat = 1 iff clipped.
- Anti-windup: saturated u (not sum) is written to u_prev.
- Write-back: e2 ← e1, e1 ← e[n], u_prev ← u.
- FSM: IDLE → MUL → ACC → OUT → IDLE.
  - IDLE: in_ready=1; accepts on in_valid; latches ch and e; reads channel state.
  - MUL: forms the three products using gains read in this cycle.
  - ACC: sum, shift, saturate.
  - OUT: out_valid=1, drives out_ch/out_u/out_sat, writes state back.
- Out-of-range in_ch (≥CH): accepted, FSM returns to IDLE with no out_valid and no state change.
- Gain writes are accepted in any state. A write to the in-flight channel during MUL or later affects the next sample only. cfg_sel=3 or cfg_ch≥CH: no effect.
- Clear zeros u_prev, e1, e2 of clr_ch; gains are untouched. If the clear hits the in-flight channel in ACC or OUT, the result is still output but write-back is suppressed; clear wins.
- No output backpressure: the consumer must take the out_valid pulse.

## Timing
- Latency: accept at edge N → out_valid high during cycle N+3. Throughput: one sample per 4 cycles.
- in_ready low in MUL, ACC and OUT; high in the cycle after OUT.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, out_ch=0, out_u=0, out_sat=0. All u_prev/e1/e2=0; gains = K*_RST.
- reset_n low mid-operation aborts the sample; no out_valid follows.
- Gain and clear writes take effect at the clock edge on which they are presented.

## Structure
- Shared package pid_pkg: FSM state enum, cfg_sel encodings, saturate function.
- One sub-module, pid_mc_regfile: per-channel state and gains, one read port, one write-back port, plus config and clear ports; handles the clear-vs-write-back priority.
- Datapath and FSM live in pid_mc.

## Test plan
- Defaults, W=8, FRAC=0, ch0, e=1 three times → u=107, 110, 115; out_sat=0 each.
- Continue with ch0 e=2 → sum 227, out_u=127, out_sat=1. Next e=0 → 127−208+2 = −79, no wind-up carried.
- Interleave ch0 e=1 and ch1 e=−1 → ch1 gives −107, −110; ch0 sequence unaffected; out_ch matches each sample.
- Write k1=16, FRAC=4 build, ch2 e=3 → out_u=3. Same write during MUL of a ch2 sample → the old gain applies to that sample.
- clr_valid on ch0 during ACC of a ch0 sample → output emitted; the next ch0 e=1 gives 107.
- reset_n pulsed low in MUL → no out_valid, in_ready=1, then ch0 e=1 gives 107.
